cdb_broadcaster: RTL and testbench

Common-data-bus arbiter and broadcaster that feeds the register rename/status table. Each functional unit hands its finished result (producing-unit tag plus value) to this block over a valid/ready handshake. The block buffers results per unit, picks one per cycle round-robin, and drives the single registered broadcast (`cdb_check`, `cdb_tag`, `cdb_value`). The rename table uses that broadcast to clear every register waiting on the tag and to latch the value.

---
 rtl/cdb_broadcaster.sv | 129 ++++++++++++
 tb/tb_cdb_broadcaster.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cdb_broadcaster.sv
// Common-data-bus arbiter: per-unit result FIFOs, round-robin pick, one registered broadcast per cycle.
// Latency: accept at edge E, broadcast at E+1 earliest; req_ready is purely registered (full => 0), stall holds grants.
module cdb_broadcaster #(
    parameter int N_UNITS                   = 4,
    parameter int UNIT_SIZE                 = 8,
    parameter int WORD_SIZE                 = 32,
    parameter int FIFO_DEPTH                = 2,
    parameter logic [UNIT_SIZE-1:0] IDLE_TAG = 'h7F
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_UNITS-1:0]             req_valid,
    output logic [N_UNITS-1:0]             req_ready,
    input  logic [N_UNITS*UNIT_SIZE-1:0]   req_tag,
    input  logic [N_UNITS*WORD_SIZE-1:0]   req_value,
    input  logic                           stall,
    output logic                           cdb_check,
    output logic [UNIT_SIZE-1:0]           cdb_tag,
    output logic [WORD_SIZE-1:0]           cdb_value,
    output logic                           busy,
    output logic                           err_badtag
);
    localparam int UW = $clog2(N_UNITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [UNIT_SIZE-1:0] r_tag_mem [N_UNITS][FIFO_DEPTH];
    logic [WORD_SIZE-1:0] r_val_mem [N_UNITS][FIFO_DEPTH];
    logic [AW-1:0]        r_wptr    [N_UNITS];
    logic [AW-1:0]        r_rptr    [N_UNITS];
    logic [CW-1:0]        r_cnt     [N_UNITS];
    logic [UW-1:0]        r_last;
    logic                 r_check;
    logic [UNIT_SIZE-1:0] r_tag;
    logic [WORD_SIZE-1:0] r_value;
    logic                 r_err;

    logic [UNIT_SIZE-1:0] w_tag [N_UNITS];
    logic [WORD_SIZE-1:0] w_val [N_UNITS];
    logic [N_UNITS-1:0]   w_nempty;
    logic [N_UNITS-1:0]   w_push;
    logic [N_UNITS-1:0]   w_pop;
    logic                 w_bad;
    logic                 w_gnt_vld;
    logic [UW-1:0]        w_gnt_idx;
    logic [UW-1:0]        w_cand;

    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < N_UNITS; i++) begin
            w_tag[i]     = req_tag[i*UNIT_SIZE +: UNIT_SIZE];
            w_val[i]     = req_value[i*WORD_SIZE +: WORD_SIZE];
            w_nempty[i]  = (r_cnt[i] != '0);
            req_ready[i] = (r_cnt[i] < CW'(FIFO_DEPTH));
            // IDLE_TAG requests complete the handshake but are dropped
            w_push[i]    = req_valid[i] && req_ready[i] && (w_tag[i] != IDLE_TAG);
            if (req_valid[i] && req_ready[i] && (w_tag[i] == IDLE_TAG))
                w_bad = 1'b1;
        end
    end

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int k = 1; k <= N_UNITS; k++) begin
            w_cand = UW'((int'(r_last) + k) % N_UNITS);
            if (!stall && !w_gnt_vld && w_nempty[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
        for (int i = 0; i < N_UNITS; i++)
            w_pop[i] = w_gnt_vld && (w_gnt_idx == UW'(i));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_UNITS; i++) begin
            if (w_push[i]) begin
                r_tag_mem[i][r_wptr[i]] <= w_tag[i];
                r_val_mem[i][r_wptr[i]] <= w_val[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_UNITS; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_UNITS; i++) begin
                if (w_push[i]) r_wptr[i] <= r_wptr[i] + 1'b1;
                if (w_pop[i])  r_rptr[i] <= r_rptr[i] + 1'b1;
                if (w_push[i] && !w_pop[i])      r_cnt[i] <= r_cnt[i] + 1'b1;
                else if (!w_push[i] && w_pop[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last  <= UW'(N_UNITS - 1);
            r_check <= 1'b0;
            r_tag   <= IDLE_TAG;
            r_value <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_bad) r_err <= 1'b1;
            if (w_gnt_vld) begin
                r_last  <= w_gnt_idx;
                r_check <= 1'b1;
                r_tag   <= r_tag_mem[w_gnt_idx][r_rptr[w_gnt_idx]];
                r_value <= r_val_mem[w_gnt_idx][r_rptr[w_gnt_idx]];
            end else begin
                r_check <= 1'b0;
                r_tag   <= IDLE_TAG;
            end
        end
    end

    assign cdb_check  = r_check;
    assign cdb_tag    = r_tag;
    assign cdb_value  = r_value;
    assign busy       = |w_nempty;
    assign err_badtag = r_err;
endmodule

// File: tb/tb_cdb_broadcaster.sv
// Randomized and directed bench for cdb_broadcaster against a queue-based reference model.
module tb_cdb_broadcaster;
    localparam int N  = 4;
    localparam int US = 8;
    localparam int WS = 32;
    localparam int D  = 2;
    localparam logic [US-1:0] IDLE = 8'h7F;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*US-1:0]   req_tag;
    logic [N*WS-1:0]   req_value;
    logic              stall;
    logic              cdb_check;
    logic [US-1:0]     cdb_tag;
    logic [WS-1:0]     cdb_value;
    logic              busy;
    logic              err_badtag;

    always #5 clk = ~clk;

    cdb_broadcaster #(.N_UNITS(N), .UNIT_SIZE(US), .WORD_SIZE(WS), .FIFO_DEPTH(D), .IDLE_TAG(IDLE)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_tag(req_tag), .req_value(req_value), .stall(stall),
        .cdb_check(cdb_check), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .busy(busy), .err_badtag(err_badtag)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model: one queue of {tag,value} per unit plus the broadcast it should show
    logic [US+WS-1:0] mq [N][$];
    int               m_last;
    logic             m_check;
    logic [US-1:0]    m_tag;
    logic [WS-1:0]    m_value;
    logic             m_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_last  = N - 1;
        m_check = 1'b0;
        m_tag   = IDLE;
        m_value = '0;
        m_err   = 1'b0;
    endtask

    task automatic check_outputs();
        logic          exp_busy;
        logic [N-1:0]  exp_rdy;
        exp_busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            exp_rdy[i] = (mq[i].size() < D);
            if (mq[i].size() > 0) exp_busy = 1'b1;
        end
        chk("cdb_check", 64'(cdb_check), 64'(m_check));
        chk("cdb_tag", 64'(cdb_tag), 64'(m_tag));
        chk("cdb_value", 64'(cdb_value), 64'(m_value));
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("err_badtag", 64'(err_badtag), 64'(m_err));
    endtask

    // one clock: check settled outputs at negedge, drive inputs, then advance model at the posedge
    task automatic cycle(input logic [N-1:0] v, input logic [N*US-1:0] t,
                         input logic [N*WS-1:0] val, input logic s);
        logic [N-1:0] mr;
        int g;
        int j;
        @(negedge clk);
        check_outputs();
        req_valid = v; req_tag = t; req_value = val; stall = s;
        for (int i = 0; i < N; i++) mr[i] = (mq[i].size() < D);
        @(posedge clk);
        g = -1;
        if (!s) begin
            for (int k = 1; k <= N; k++) begin
                j = (m_last + k) % N;
                if (g < 0 && mq[j].size() > 0) g = j;
            end
        end
        if (g >= 0) begin
            {m_tag, m_value} = mq[g].pop_front();
            m_check = 1'b1;
            m_last  = g;
        end else begin
            m_check = 1'b0;
            m_tag   = IDLE;
        end
        for (int i = 0; i < N; i++) begin
            if (v[i] && mr[i]) begin
                if (t[i*US +: US] == IDLE) m_err = 1'b1;
                else mq[i].push_back({t[i*US +: US], val[i*WS +: WS]});
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        req_valid = '0; stall = 1'b0;
        model_reset();
        #1;
        chk("rst_check", 64'(cdb_check), 64'(0));
        chk("rst_tag", 64'(cdb_tag), 64'(IDLE));
        chk("rst_value", 64'(cdb_value), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(4'hF));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err", 64'(err_badtag), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [N*US-1:0] rt;
    logic [N*WS-1:0] rv;

    initial begin
        rst_n = 1'b1; req_valid = '0; req_tag = '0; req_value = '0; stall = 1'b0;
        model_reset();
        do_reset();

        // single uncontested result: broadcast one edge after acceptance
        cycle(4'b0100, {8'h0, 8'h02, 16'h0}, {32'h0, 32'hDEADBEEF, 64'h0}, 1'b0);
        cycle('0, '0, '0, 1'b0);
        #1;
        chk("t1_check", 64'(cdb_check), 64'(1));
        chk("t1_tag", 64'(cdb_tag), 64'h02);
        chk("t1_value", 64'(cdb_value), 64'hDEADBEEF);
        cycle('0, '0, '0, 1'b0);
        #1;
        chk("t1_drop", 64'(cdb_check), 64'(0));
        chk("t1_idle", 64'(cdb_tag), 64'h7F);
        chk("t1_hold", 64'(cdb_value), 64'hDEADBEEF);

        // all units at once after reset: tag order 00..03
        do_reset();
        cycle(4'hF, {8'h03, 8'h02, 8'h01, 8'h00}, {32'd13, 32'd12, 32'd11, 32'd10}, 1'b0);
        for (int k = 0; k < N; k++) begin
            cycle('0, '0, '0, 1'b0);
            #1;
            chk("t2_order", 64'(cdb_tag), 64'(k));
        end
        chk("t2_busy", 64'(busy), 64'(0));

        // unit 1 bursts three results while unit 0 is busy
        do_reset();
        cycle(4'b0011, {16'h0, 8'h21, 8'h10}, {64'h0, 32'd1, 32'd100}, 1'b0);
        cycle(4'b0011, {16'h0, 8'h22, 8'h11}, {64'h0, 32'd2, 32'd101}, 1'b0);
        #1;
        chk("t3_full", 64'(req_ready[1]), 64'(0));
        for (int k = 0; k < 5; k++)
            cycle(4'b0010, {16'h0, 8'h23, 8'h0}, {64'h0, 32'd3, 32'd0}, 1'b0);
        idle(4);

        // stall with two units loaded: nothing broadcast, then resume from the saved pointer
        cycle(4'b1001, {8'h33, 16'h0, 8'h30}, {32'd7, 64'h0, 32'd6}, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle('0, '0, '0, 1'b1);
            #1;
            chk("t4_stall", 64'(cdb_check), 64'(0));
        end
        idle(3);

        // IDLE_TAG request is swallowed and flags the sticky error
        cycle(4'b1000, {IDLE, 24'h0}, {32'd5, 96'h0}, 1'b0);
        idle(2);
        #1;
        chk("t5_err", 64'(err_badtag), 64'(1));

        // randomized traffic with occasional stalls and bad tags
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                rt[i*US +: US] = ($urandom_range(0, 31) == 0) ? IDLE : 8'($urandom_range(0, 126));
                rv[i*WS +: WS] = $urandom;
            end
            cycle(4'($urandom), rt, rv, ($urandom_range(0, 7) == 0));
        end

        // reset asserted mid-burst with FIFOs loaded
        cycle(4'hF, {8'h43, 8'h42, 8'h41, 8'h40}, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);
        cycle(4'hF, {8'h53, 8'h52, 8'h51, 8'h50}, {32'd8, 32'd7, 32'd6, 32'd5}, 1'b0);
        do_reset();
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
